pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Control FSM that sequences the program counter register for the RISC-V core.
- Drives the PC's pc_in/enable inputs and runs a request/ack fetch handshake with instruction memory.
- Presents each fetched instruction to decode for one EXEC cycle.
- Selects the next PC: sequential +4, branch/jump redirect, trap vector, or hold (stall/halt).

Parameters:
RESET_VECTOR, 32'h0000_0000, PC loaded on leaving reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or misaligned redirect
XLEN, 32, address/PC width

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
pc_cur  in  XLEN  current PC register value (PC.pc_out)
pc_in  out  XLEN  next-PC value to PC register
pc_enable  out  1  PC load strobe; PC captures pc_in when high
fetch_req  out  1  instruction-memory request
fetch_addr  out  XLEN  fetch address (= pc_cur while fetch_req)
fetch_ack  in  1  memory has returned the instruction (single-cycle pulse)
instr_valid  out  1  instruction valid to decode/execute
stall  in  1  hazard hold, sampled in EXEC only
redirect  in  1  taken branch/jump, sampled in EXEC only
redirect_target  in  XLEN  branch/jump destination
trap  in  1  illegal-instruction/exception from decode, sampled in EXEC
halt_req  in  1  ecall/ebreak halt, sampled in EXEC
halted  out  1  core halted (sticky until reset)
state_dbg  out  2  encoded FSM state for the bench
retired_count  out  XLEN  instructions retired, wraps modulo 2^XLEN

Behaviour:
- Reset (rst_n low at posedge):
  - state=BOOT; retired_count=0.
  - All strobes 0: pc_enable, fetch_req, instr_valid, halted. pc_in=0.
  - Reset overrides any in-flight fetch or EXEC; a fetch_ack arriving during reset is ignored.
- States: BOOT=0, FETCH=1, EXEC=2, HALT=3.
- BOOT: pc_enable=1, pc_in=RESET_VECTOR for exactly one cycle -> FETCH.
- FETCH:
  - fetch_req=1, fetch_addr=pc_cur; fetch_req held high until fetch_ack.
  - fetch_ack high -> EXEC next cycle. No timeout.
  - redirect/trap/stall/halt_req ignored in FETCH.
- EXEC: instr_valid=1. Inputs evaluated in this priority order:
  1. trap, or redirect with redirect_target[1:0]!=0: pc_in=TRAP_VECTOR, pc_enable=1 -> FETCH. retired_count unchanged.
  2. redirect (aligned target): pc_in=redirect_target, pc_enable=1, retired_count+1 -> FETCH.
  3. halt_req: pc_enable=0, retired_count+1 -> HALT.
  4. stall: pc_enable=0, stay in EXEC with instr_valid held high, counter unchanged.
  5. Otherwise: pc_in=pc_cur+4 (mod 2^XLEN, 32'hFFFF_FFFC wraps to 0), pc_enable=1, retired_count+1 -> FETCH.
- HALT: halted=1, all strobes 0, PC frozen; only exit is reset.
- pc_in/pc_enable are combinational from state and inputs. The PC updates at the EXEC->FETCH edge, so the next FETCH uses the new pc_cur.
- pc_in is 0 whenever pc_enable=0.
- Minimum instruction period: 2 cycles (FETCH with immediate ack + EXEC).
- Simultaneous events are fully resolved by the priority above; stall never blocks trap, redirect or halt.

Decomposition:
- Shared package pc_seq_pkg: state encoding constants (ST_BOOT, ST_FETCH, ST_EXEC, ST_HALT), PC_STEP=4, default vectors.
- Optional sub-module next_pc_mux: combinational priority select of pc_in/pc_enable/trap-taken. FSM and counter stay in pc_sequencer.

Test Plan:
- Reset then release, fetch_ack tied high -> one BOOT cycle loads 0. pc_cur sequence 0,4,8,12 on successive FETCHes; retired_count=3 after the 3rd EXEC.
- fetch_ack delayed 3 cycles -> fetch_req and fetch_addr stable for 4 cycles; no pc_enable during FETCH.
- EXEC at PC=8 with stall high 2 cycles -> instr_valid high 3 cycles, PC stays 8, then advances to 12; counter +1 only.
- EXEC at PC=8 with redirect=1, target=0x40 -> next FETCH addr 0x40. Repeat with target=0x42 -> fetch addr 0x100, counter unchanged.
- EXEC with trap=1, redirect=1 and stall=1 together -> trap wins: PC=0x100, counter unchanged.
- halt_req in EXEC -> HALT, halted=1, PC frozen 20 cycles. rst_n low mid-FETCH -> BOOT, counter 0, halted=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: state encoding,
// next-PC selection codes, default vectors and the alignment helper.
package pc_seq_pkg;

    localparam int unsigned XLEN_DEF = 32;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam int unsigned PC_STEP = 4;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

    typedef enum logic [2:0] {
        SEL_HOLD  = 3'd0,
        SEL_BOOT  = 3'd1,
        SEL_TRAP  = 3'd2,
        SEL_REDIR = 3'd3,
        SEL_HALT  = 3'd4,
        SEL_STALL = 3'd5,
        SEL_SEQ   = 3'd6
    } pc_sel_e;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Priority select of the next PC value and load strobe; also reports which
// resolution was taken so the FSM can pick its next state and retire count.
module next_pc_mux
    import pc_seq_pkg::*;
#(
    parameter int unsigned     XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF)
) (
    input  logic            i_boot,
    input  logic            i_exec,
    input  logic [XLEN-1:0] i_pc_cur,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_target,
    input  logic            i_trap,
    input  logic            i_halt_req,
    input  logic            i_stall,
    output logic [XLEN-1:0] o_pc_in,
    output logic            o_pc_enable,
    output logic            o_trap_taken,
    output pc_sel_e         o_sel
);

    // Resolve simultaneous EXEC events strictly by priority; stall is lowest.
    always_comb begin
        o_sel       = SEL_HOLD;
        o_pc_in     = {XLEN{1'b0}};
        o_pc_enable = 1'b0;
        if (i_boot) begin
            o_sel       = SEL_BOOT;
            o_pc_in     = RESET_VECTOR;
            o_pc_enable = 1'b1;
        end else if (i_exec) begin
            if (i_trap || (i_redirect && is_misaligned(i_redirect_target[1:0]))) begin
                o_sel       = SEL_TRAP;
                o_pc_in     = TRAP_VECTOR;
                o_pc_enable = 1'b1;
            end else if (i_redirect) begin
                o_sel       = SEL_REDIR;
                o_pc_in     = i_redirect_target;
                o_pc_enable = 1'b1;
            end else if (i_halt_req) begin
                o_sel       = SEL_HALT;
            end else if (i_stall) begin
                o_sel       = SEL_STALL;
            end else begin
                o_sel       = SEL_SEQ;
                o_pc_in     = i_pc_cur + XLEN'(PC_STEP);
                o_pc_enable = 1'b1;
            end
        end else begin
            o_sel = SEL_HOLD;
        end
    end

    assign o_trap_taken = (o_sel == SEL_TRAP);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute control FSM for the core's program counter: boot load,
// request/ack fetch, one-cycle EXEC presentation and next-PC selection.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned     XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_cur,
    output logic [XLEN-1:0] pc_in,
    output logic            pc_enable,
    output logic            fetch_req,
    output logic [XLEN-1:0] fetch_addr,
    input  logic            fetch_ack,
    output logic            instr_valid,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap,
    input  logic            halt_req,
    output logic            halted,
    output logic [1:0]      state_dbg,
    output logic [XLEN-1:0] retired_count
);

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_retired;
    logic [1:0]      w_state_nxt;
    logic            w_boot;
    logic            w_exec;
    logic            w_retire;
    logic            w_trap_taken;
    logic [XLEN-1:0] w_pc_in;
    logic            w_pc_enable;
    pc_sel_e         w_sel;

    // While reset is held every strobe is forced low, even though the
    // register already reads BOOT.
    assign w_boot = rst_n && (r_state == ST_BOOT);
    assign w_exec = rst_n && (r_state == ST_EXEC);

    next_pc_mux #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RESET_VECTOR),
        .TRAP_VECTOR  (TRAP_VECTOR)
    ) u_next_pc_mux (
        .i_boot            (w_boot),
        .i_exec            (w_exec),
        .i_pc_cur          (pc_cur),
        .i_redirect        (redirect),
        .i_redirect_target (redirect_target),
        .i_trap            (trap),
        .i_halt_req        (halt_req),
        .i_stall           (stall),
        .o_pc_in           (w_pc_in),
        .o_pc_enable       (w_pc_enable),
        .o_trap_taken      (w_trap_taken),
        .o_sel             (w_sel)
    );

    assign w_retire = (w_sel == SEL_REDIR) || (w_sel == SEL_HALT) || (w_sel == SEL_SEQ);

    // Next-state decode; EXEC exits follow the mux's resolution.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT:  w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (fetch_ack) begin
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_EXEC: begin
                case (w_sel)
                    SEL_HALT:  w_state_nxt = ST_HALT;
                    SEL_STALL: w_state_nxt = ST_EXEC;
                    default:   w_state_nxt = w_trap_taken ? ST_FETCH : ST_FETCH;
                endcase
            end
            ST_HALT:  w_state_nxt = ST_HALT;
            default:  w_state_nxt = ST_BOOT;
        endcase
    end

    // State and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_BOOT;
            r_retired <= {XLEN{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if (w_retire) begin
                r_retired <= r_retired + {{(XLEN-1){1'b0}}, 1'b1};
            end else begin
                r_retired <= r_retired;
            end
        end
    end

    assign pc_in         = w_pc_enable ? w_pc_in : {XLEN{1'b0}};
    assign pc_enable     = w_pc_enable;
    assign fetch_req     = rst_n && (r_state == ST_FETCH);
    assign fetch_addr    = fetch_req ? pc_cur : {XLEN{1'b0}};
    assign instr_valid   = w_exec;
    assign halted        = rst_n && (r_state == ST_HALT);
    assign state_dbg     = r_state;
    assign retired_count = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural PC register closing the loop.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_cur = 32'h1234_5678;
    logic [31:0] pc_in;
    logic        pc_enable;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic        instr_valid;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        trap;
    logic        halt_req;
    logic        halted;
    logic [1:0]  state_dbg;
    logic [31:0] retired_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // PC register as seen by the sequencer
    always @(posedge clk) begin
        if (pc_enable) pc_cur <= pc_in;
    end

    pc_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_cur          (pc_cur),
        .pc_in           (pc_in),
        .pc_enable       (pc_enable),
        .fetch_req       (fetch_req),
        .fetch_addr      (fetch_addr),
        .fetch_ack       (fetch_ack),
        .instr_valid     (instr_valid),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .trap            (trap),
        .halt_req        (halt_req),
        .halted          (halted),
        .state_dbg       (state_dbg),
        .retired_count   (retired_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_fetch(input string tag, input logic [31:0] addr, input logic [31:0] ret);
        chk({tag, "_state"}, 32'(state_dbg), 32'd1);
        chk({tag, "_req"}, 32'(fetch_req), 32'd1);
        chk({tag, "_addr"}, fetch_addr, addr);
        chk({tag, "_en"}, 32'(pc_enable), 32'd0);
        chk({tag, "_ret"}, retired_count, ret);
    endtask

    task automatic chk_exec(input string tag, input logic en, input logic [31:0] nxt);
        chk({tag, "_state"}, 32'(state_dbg), 32'd2);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, "_en"}, 32'(pc_enable), 32'(en));
        chk({tag, "_pcin"}, pc_in, nxt);
    endtask

    task automatic clr_ctl();
        stall = 1'b0; redirect = 1'b0; trap = 1'b0; halt_req = 1'b0;
        redirect_target = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0; fetch_ack = 1'b1;
        clr_ctl();

        // reset held with ack high: ack ignored, strobes low
        repeat (3) @(negedge clk);
        #1;
        chk("rst_state", 32'(state_dbg), 32'd0);
        chk("rst_en", 32'(pc_enable), 32'd0);
        chk("rst_pcin", pc_in, 32'h0);
        chk("rst_req", 32'(fetch_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_ret", retired_count, 32'd0);

        @(negedge clk); rst_n = 1'b1; #1;
        chk("boot_state", 32'(state_dbg), 32'd0);
        chk("boot_en", 32'(pc_enable), 32'd1);
        chk("boot_pcin", pc_in, 32'h0);

        // three sequential instructions with immediate ack
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk_fetch("seq_f", 32'(4 * i), 32'(i));
            @(negedge clk); #1;
            chk_exec("seq_e", 1'b1, 32'(4 * i + 4));
        end

        // ack delayed: request held 4 cycles at PC 12
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); fetch_ack = (k == 3); #1;
            chk_fetch("dly_f", 32'd12, 32'd3);
        end

        // stall two cycles in EXEC, then advance once
        @(negedge clk); stall = 1'b1; #1;
        chk_exec("stall0", 1'b0, 32'h0);
        @(negedge clk); #1;
        chk_exec("stall1", 1'b0, 32'h0);
        chk("stall1_ret", retired_count, 32'd3);
        @(negedge clk); stall = 1'b0; #1;
        chk_exec("stall2", 1'b1, 32'd16);

        @(negedge clk); #1;
        chk_fetch("post_stall_f", 32'd16, 32'd4);
        @(negedge clk); redirect = 1'b1; redirect_target = 32'h40; #1;
        chk_exec("redir_e", 1'b1, 32'h40);

        @(negedge clk); clr_ctl(); #1;
        chk_fetch("redir_f", 32'h40, 32'd5);
        @(negedge clk); redirect = 1'b1; redirect_target = 32'h42; #1;
        chk_exec("misal_e", 1'b1, 32'h100);

        @(negedge clk); clr_ctl(); #1;
        chk_fetch("misal_f", 32'h100, 32'd5);
        @(negedge clk);
        trap = 1'b1; redirect = 1'b1; redirect_target = 32'h80; stall = 1'b1; #1;
        chk_exec("trap_e", 1'b1, 32'h100);

        @(negedge clk); clr_ctl(); #1;
        chk_fetch("trap_f", 32'h100, 32'd5);
        @(negedge clk); redirect = 1'b1; redirect_target = 32'hFFFF_FFFC; #1;
        chk_exec("top_e", 1'b1, 32'hFFFF_FFFC);

        @(negedge clk); clr_ctl(); #1;
        chk_fetch("top_f", 32'hFFFF_FFFC, 32'd6);
        @(negedge clk); #1;
        chk_exec("wrap_e", 1'b1, 32'h0);

        @(negedge clk); #1;
        chk_fetch("wrap_f", 32'h0, 32'd7);
        @(negedge clk); halt_req = 1'b1; stall = 1'b1; #1;
        chk_exec("halt_e", 1'b0, 32'h0);

        // halted: everything frozen regardless of inputs
        @(negedge clk); clr_ctl(); redirect = 1'b1; redirect_target = 32'h200; #1;
        for (int k = 0; k < 20; k++) begin
            chk("halt_state", 32'(state_dbg), 32'd3);
            chk("halt_flag", 32'(halted), 32'd1);
            chk("halt_en", 32'(pc_enable | fetch_req | instr_valid), 32'd0);
            chk("halt_pc", pc_cur, 32'h0);
            chk("halt_ret", retired_count, 32'd8);
            @(negedge clk); #1;
        end

        // reset out of HALT
        clr_ctl(); rst_n = 1'b0;
        @(negedge clk); #1;
        chk("rst2_halted", 32'(halted), 32'd0);
        chk("rst2_ret", retired_count, 32'd0);
        chk("rst2_state", 32'(state_dbg), 32'd0);

        // one instruction, then reset during a pending fetch
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        chk_fetch("rst3_f0", 32'h0, 32'd0);
        @(negedge clk); #1;
        chk_exec("rst3_e", 1'b1, 32'd4);
        @(negedge clk); fetch_ack = 1'b0; #1;
        chk_fetch("rst3_f1", 32'd4, 32'd1);
        @(negedge clk); rst_n = 1'b0; fetch_ack = 1'b1; #1;
        chk("midrst_req", 32'(fetch_req), 32'd0);
        chk("midrst_en", 32'(pc_enable), 32'd0);
        @(negedge clk); #1;
        chk("midrst_state", 32'(state_dbg), 32'd0);
        chk("midrst_ret", retired_count, 32'd0);
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("reboot_pcin", pc_in, 32'h0);
        @(negedge clk); #1;
        chk_fetch("reboot_f", 32'h0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
